fifo_sync_ext: RTL and testbench
================================

// Module: fifo_sync_ext
// PURPOSE
//  Next-generation single-clock FIFO: any depth >= 2 (not only powers of 2), exact fill level output.
//  Runtime-programmable almost-full/almost-empty thresholds; standard or first-word-fall-through (FWFT) read mode.
//  Simultaneous push+pop is handled correctly, including at full.
//  Used as the generic buffer between stream producers/consumers in the datapath.
// PARAMETERS
//  DEPTH   8  number of entries, >= 2, any integer
//  DATA_W  8  data width in bits
//  FWFT    0  0 = registered read (1-cycle latency), 1 = first-word-fall-through
//  derived: PTR_W = $clog2(DEPTH), LVL_W = $clog2(DEPTH+1)
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high reset
//  clk_enable    in   1       qualifies every state update; when 0 all state holds
//  write         in   1       push request
//  write_data    in   DATA_W  push data
//  read          in   1       pop request
//  read_data     out  DATA_W  pop data (see BEHAVIOUR)
//  read_valid    out  1       read_data holds newly popped data (FWFT=0), or = !empty (FWFT=1)
//  af_thresh     in   LVL_W   almost-full threshold
//  ae_thresh     in   LVL_W   almost-empty threshold
//  level         out  LVL_W   current entry count, 0..DEPTH
//  full          out  1       level == DEPTH
//  empty         out  1       level == 0
//  almost_full   out  1       level >= af_thresh
//  almost_empty  out  1       level <= ae_thresh
//  overflow      out  1       sticky error flags, present only with FIFO_ERR_FLAGS_EN
//  underflow     out  1       sticky error flags, present only with FIFO_ERR_FLAGS_EN
//  err_clear     in   1       clears overflow/underflow, present only with FIFO_ERR_FLAGS_EN
// BEHAVIOUR
//  - Reset: wr_ptr = rd_ptr = 0, level = 0, read_data = 0, read_valid = 0.
//    Flags after reset: empty = 1, full = 0, overflow = underflow = 0. Memory contents are not cleared.
//  - Reset wins over clk_enable and all requests; a mid-stream reset discards all contents in one cycle.
//  - pop_ok = clk_enable & read & !empty.
//  - push_ok = clk_enable & write & (!full | pop_ok): a push at full is accepted if a pop happens in the same cycle.
//  - A push at empty together with a read: the pop is rejected (empty) and the push is accepted.
//  - level <= level + push_ok - pop_ok, computed in LVL_W+1 bits; never leaves 0..DEPTH.
//  - Pointers increment on push_ok/pop_ok and wrap DEPTH-1 -> 0 explicitly (no power-of-2 assumption).
//  - FWFT=0: read_data <= mem[rd_ptr] on pop_ok (available the cycle after the pop); otherwise read_data holds.
//    read_valid is a 1-cycle pulse the cycle after pop_ok.
//  - FWFT=1: read_data = mem[rd_ptr] combinationally whenever !empty; read acts as acknowledge/pop.
//    read_valid = !empty. A written word is visible the cycle after the push.
//  - Flags are combinational from level. Thresholds may change any cycle; flags track them immediately.
//  - af_thresh = 0 forces almost_full = 1. ae_thresh >= DEPTH forces almost_empty = 1.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//   - overflow sets on clk_enable & write & !push_ok; underflow sets on clk_enable & read & empty.
//   - Both flags stay set until err_clear or reset. If err_clear and a new error occur in the same cycle, the set wins.
//  FIFO_ERR_FLAGS_EN undefined: ports overflow, underflow and err_clear are absent; rejected requests are silently dropped.
// STRUCTURE
//  - Shared package fifo_pkg: ptr_inc(ptr, depth) wrap function and the LVL_W/PTR_W width helpers, reused by other FIFOs.
//  - Sub-module fifo_ram_2p: DEPTH x DATA_W memory, 1 write port, async read port.
//    Top level holds pointers, level, flags and the read-mode output stage.
// TESTING
//  1 DEPTH=5: reset, 5 pushes 0x11..0x15 -> level=5, full=1; 6th push -> dropped, overflow=1 if EN; 5 pops -> 0x11..0x15 in order, empty=1.
//  2 Wrap: DEPTH=5, 3 pushes, 3 pops, repeated 4x -> data order preserved across pointer wrap, level back to 0.
//  3 At full, push 0xAA + pop in the same cycle -> level stays 5, oldest word out, 0xAA becomes tail.
//  4 Empty + push + read same cycle -> pop rejected, level=1, underflow=1 if EN; FWFT=1: read_data=push value next cycle.
//  5 af_thresh=4, ae_thresh=1: level sweep 0..5 -> almost_empty 1 at 0..1; almost_full 1 at 4..5; change af_thresh to 2 at level 3 -> almost_full=1 same cycle.
//  6 clk_enable=0 with write/read active -> no state change; reset asserted at level 3 -> level=0, empty=1, read_data=0 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO width helpers, pointer wrap function and status types
package fifo_pkg;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap at depth-1 so non power-of-2 depths need no spare entries.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sync_ext_if.sv
// rtl/fifo_sync_ext_if.sv - FIFO push/pop/status bundle; FIFO_ERR_FLAGS_EN adds overflow/underflow/err_clear
interface fifo_sync_ext_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
);
    import fifo_pkg::*;

    localparam int LVL_W = lvl_w(DEPTH);

    logic              write;
    logic [DATA_W-1:0] write_data;
    logic              read;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic [LVL_W-1:0]  af_thresh;
    logic [LVL_W-1:0]  ae_thresh;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
    logic              err_clear;
`endif

    modport master (
        output write, write_data, read, af_thresh, ae_thresh,
`ifdef FIFO_ERR_FLAGS_EN
        output err_clear,
        input  overflow, underflow,
`endif
        input  read_data, read_valid, level, full, empty, almost_full, almost_empty
    );

    modport slave (
        input  write, write_data, read, af_thresh, ae_thresh,
`ifdef FIFO_ERR_FLAGS_EN
        input  err_clear,
        output overflow, underflow,
`endif
        output read_data, read_valid, level, full, empty, almost_full, almost_empty
    );

endinterface

// File: rtl/fifo_ram_2p.sv
// rtl/fifo_ram_2p.sv - DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_ext.sv
// rtl/fifo_sync_ext.sv - single-clock FIFO, any depth, exact level, FWFT option; FIFO_ERR_FLAGS_EN adds sticky error flags
module fifo_sync_ext
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int FWFT   = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_enable,
    fifo_sync_ext_if.slave bus
);

    localparam int       PTR_W   = ptr_w(DEPTH);
    localparam int       LVL_W   = lvl_w(DEPTH);
    localparam rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W:0]    level_next;
    logic [DATA_W-1:0] ram_rdata;
    logic              push_ok;
    logic              pop_ok;
    fifo_flags_t       flags;

    always_comb begin
        flags.full         = (level_q == LVL_W'(DEPTH));
        flags.empty        = (level_q == '0);
        flags.almost_full  = (level_q >= bus.af_thresh);
        flags.almost_empty = (level_q <= bus.ae_thresh);
    end

    // A push at full rides on a same-cycle pop; a pop at empty is never granted.
    assign pop_ok  = clk_enable & bus.read & ~flags.empty;
    assign push_ok = clk_enable & bus.write & (~flags.full | pop_ok);

    assign level_next = {1'b0, level_q}
                      + {{LVL_W{1'b0}}, push_ok}
                      - {{LVL_W{1'b0}}, pop_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (clk_enable) begin
            if (push_ok) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
            end
            if (pop_ok) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
            end
            // MSB marks an impossible wrap below 0; holding keeps level inside 0..DEPTH.
            if (!level_next[LVL_W]) begin
                level_q <= level_next[LVL_W-1:0];
            end
        end
    end

    fifo_ram_2p #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok & ~reset),
        .waddr (wr_ptr),
        .wdata (bus.write_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign bus.level        = level_q;
    assign bus.full         = flags.full;
    assign bus.empty        = flags.empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.almost_empty = flags.almost_empty;

    if (RD_MODE == RD_FWFT) begin : g_fwft
        assign bus.read_data  = flags.empty ? '0 : ram_rdata;
        assign bus.read_valid = ~flags.empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (clk_enable) begin
                rd_valid_q <= pop_ok;
                if (pop_ok) begin
                    rd_data_q <= ram_rdata;
                end
            end
        end

        assign bus.read_data  = rd_data_q;
        assign bus.read_valid = rd_valid_q;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;
    logic overflow_set;
    logic underflow_set;

    assign overflow_set  = clk_enable & bus.write & ~push_ok;
    assign underflow_set = clk_enable & bus.read & flags.empty;

    // A new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clk_enable) begin
            overflow_q  <= overflow_set  | (overflow_q  & ~bus.err_clear);
            underflow_q <= underflow_set | (underflow_q & ~bus.err_clear);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ext.sv
// tb/tb_fifo_sync_ext.sv - registered and FWFT instances side by side against a queue model; honours FIFO_ERR_FLAGS_EN
module tb_fifo_sync_ext;
    import fifo_pkg::*;

    localparam int DEPTH  = 5;
    localparam int DATA_W = 8;
    localparam int LVL_W  = lvl_w(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              clk_enable;
    logic              write;
    logic [DATA_W-1:0] write_data;
    logic              read;
    logic              err_clear;
    logic [LVL_W-1:0]  af_thresh;
    logic [LVL_W-1:0]  ae_thresh;

    fifo_sync_ext_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus0 ();
    fifo_sync_ext_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus1 ();

    assign bus0.write      = write;
    assign bus0.write_data = write_data;
    assign bus0.read       = read;
    assign bus0.af_thresh  = af_thresh;
    assign bus0.ae_thresh  = ae_thresh;
    assign bus1.write      = write;
    assign bus1.write_data = write_data;
    assign bus1.read       = read;
    assign bus1.af_thresh  = af_thresh;
    assign bus1.ae_thresh  = ae_thresh;
`ifdef FIFO_ERR_FLAGS_EN
    assign bus0.err_clear  = err_clear;
    assign bus1.err_clear  = err_clear;
`endif

    fifo_sync_ext #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FWFT(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus0)
    );

    fifo_sync_ext #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FWFT(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: contents as a queue, registered read port as last popped word.
    logic [7:0] q[$];
    logic [7:0] m_rd0;
    bit         m_rv0;
    bit         m_ovf;
    bit         m_udf;

    typedef struct {
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        int         lvl;
        bit         full;
        bit         empty;
        bit         rv0;
        logic [7:0] rd0;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        bit was_empty;
        if (reset) begin
            q.delete();
            m_rd0 = 8'h00;
            m_rv0 = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (clk_enable) begin
            was_empty = (q.size() == 0);
            pop  = read && !was_empty;
            push = write && (q.size() < DEPTH || pop);
            m_ovf = (write && !push) || (m_ovf && !err_clear);
            m_udf = (read && was_empty) || (m_udf && !err_clear);
            m_rv0 = pop;
            if (pop) m_rd0 = q.pop_front();
            if (push) q.push_back(write_data);
        end
    endtask

    task automatic check_all();
        int         n;
        logic [7:0] head;
        n = q.size();
        head = (n != 0) ? q[0] : 8'h00;
        chk("level0", 32'(bus0.level), 32'(n));
        chk("level1", 32'(bus1.level), 32'(n));
        chk("full0", 32'(bus0.full), 32'(n == DEPTH));
        chk("full1", 32'(bus1.full), 32'(n == DEPTH));
        chk("empty0", 32'(bus0.empty), 32'(n == 0));
        chk("empty1", 32'(bus1.empty), 32'(n == 0));
        chk("afull0", 32'(bus0.almost_full), 32'(n >= int'(af_thresh)));
        chk("afull1", 32'(bus1.almost_full), 32'(n >= int'(af_thresh)));
        chk("aempty0", 32'(bus0.almost_empty), 32'(n <= int'(ae_thresh)));
        chk("aempty1", 32'(bus1.almost_empty), 32'(n <= int'(ae_thresh)));
        chk("rdata_reg", 32'(bus0.read_data), 32'(m_rd0));
        chk("rvalid_reg", 32'(bus0.read_valid), 32'(m_rv0));
        chk("rdata_fwft", 32'(bus1.read_data), 32'(head));
        chk("rvalid_fwft", 32'(bus1.read_valid), 32'(n != 0));
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow0", 32'(bus0.overflow), 32'(m_ovf));
        chk("overflow1", 32'(bus1.overflow), 32'(m_ovf));
        chk("underflow0", 32'(bus0.underflow), 32'(m_udf));
        chk("underflow1", 32'(bus1.underflow), 32'(m_udf));
`endif
    endtask

    task automatic drive(input bit rst, input bit ce, input bit wr, input logic [7:0] wd, input bit rd);
        reset      = rst;
        clk_enable = ce;
        write      = wr;
        write_data = wd;
        read       = rd;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        drive(1, 1, 0, 8'h00, 0);
        step();
        drive(0, 1, 0, 8'h00, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp3[5];
        logic [5:0] ae_mask;
        logic [5:0] af_mask;
        int         wp;

        err_clear = 1'b0;
        af_thresh = LVL_W'(4);
        ae_thresh = LVL_W'(1);
        drive(1, 1, 0, 8'h00, 0);
        step();
        step();
        chk("rst_level", 32'(bus0.level), 0);
        chk("rst_empty", 32'(bus0.empty), 1);
        chk("rst_full", 32'(bus0.full), 0);
        chk("rst_rvalid_reg", 32'(bus0.read_valid), 0);
        chk("rst_rdata_reg", 32'(bus0.read_data), 0);
        chk("rst_rdata_fwft", 32'(bus1.read_data), 0);

        // Fill to full, one rejected push, drain, one rejected pop.
        vecs = '{
            '{1, 8'h11, 0, 1, 0, 0, 0, 8'h00},
            '{1, 8'h12, 0, 2, 0, 0, 0, 8'h00},
            '{1, 8'h13, 0, 3, 0, 0, 0, 8'h00},
            '{1, 8'h14, 0, 4, 0, 0, 0, 8'h00},
            '{1, 8'h15, 0, 5, 1, 0, 0, 8'h00},
            '{1, 8'h16, 0, 5, 1, 0, 0, 8'h00},
            '{0, 8'h00, 1, 4, 0, 0, 1, 8'h11},
            '{0, 8'h00, 1, 3, 0, 0, 1, 8'h12},
            '{0, 8'h00, 1, 2, 0, 0, 1, 8'h13},
            '{0, 8'h00, 1, 1, 0, 0, 1, 8'h14},
            '{0, 8'h00, 1, 0, 0, 1, 1, 8'h15},
            '{0, 8'h00, 1, 0, 0, 1, 0, 8'h15}
        };
        drive(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            step();
            chk($sformatf("vec%0d_level", i), 32'(bus0.level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_full", i), 32'(bus0.full), 32'(vecs[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(bus0.empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d_rvalid", i), 32'(bus0.read_valid), 32'(vecs[i].rv0));
            chk($sformatf("vec%0d_rdata", i), 32'(bus0.read_data), 32'(vecs[i].rd0));
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("t1_overflow", 32'(bus0.overflow), 1);
        chk("t1_underflow", 32'(bus1.underflow), 1);
        drive(0, 1, 0, 8'h00, 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t1_overflow_clr", 32'(bus0.overflow), 0);
`endif

        // Pointer wrap: 3 in / 3 out, four rounds on a 5-entry FIFO.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                drive(0, 1, 1, 8'(8'h30 + r * 3 + k), 0);
                step();
            end
            for (int k = 0; k < 3; k++) begin
                drive(0, 1, 0, 8'h00, 1);
                step();
                chk("wrap_data", 32'(bus0.read_data), 32'(8'(8'h30 + r * 3 + k)));
            end
        end
        chk("wrap_level", 32'(bus0.level), 0);

        // Push and pop together at full.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 1, 8'(8'h21 + k), 0);
            step();
        end
        drive(0, 1, 1, 8'hAA, 1);
        step();
        chk("full_pp_level", 32'(bus0.level), 5);
        chk("full_pp_oldest", 32'(bus0.read_data), 32'h21);
        chk("full_pp_fwft_head", 32'(bus1.read_data), 32'h22);
        exp3 = '{8'h22, 8'h23, 8'h24, 8'h25, 8'hAA};
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 8'h00, 1);
            step();
            chk("full_pp_drain", 32'(bus0.read_data), 32'(exp3[k]));
        end

        // Push plus read while empty.
        do_reset();
        drive(0, 1, 1, 8'h5A, 1);
        step();
        chk("empty_pr_level", 32'(bus0.level), 1);
        chk("empty_pr_rvalid_reg", 32'(bus0.read_valid), 0);
        chk("empty_pr_fwft_data", 32'(bus1.read_data), 32'h5A);
        chk("empty_pr_fwft_valid", 32'(bus1.read_valid), 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("empty_pr_underflow", 32'(bus0.underflow), 1);
`endif

        // Threshold sweep and live threshold changes.
        do_reset();
        ae_mask = 6'b000011;
        af_mask = 6'b110000;
        chk("sweep_ae_0", 32'(bus0.almost_empty), 32'(ae_mask[0]));
        chk("sweep_af_0", 32'(bus0.almost_full), 32'(af_mask[0]));
        af_thresh = LVL_W'(0);
        #1;
        chk("af_zero_forces", 32'(bus0.almost_full), 1);
        af_thresh = LVL_W'(4);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 1, 8'(8'h40 + k), 0);
            step();
            chk($sformatf("sweep_ae_%0d", k), 32'(bus0.almost_empty), 32'(ae_mask[k]));
            chk($sformatf("sweep_af_%0d", k), 32'(bus1.almost_full), 32'(af_mask[k]));
            if (k == 3) begin
                af_thresh = LVL_W'(2);
                #1;
                chk("af_change_same_cycle", 32'(bus0.almost_full), 1);
                af_thresh = LVL_W'(4);
                #1;
            end
        end
        ae_thresh = LVL_W'(7);
        #1;
        chk("ae_big_forces", 32'(bus0.almost_empty), 1);
        ae_thresh = LVL_W'(1);

        // clk_enable low freezes everything; reset beats clk_enable and requests.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 8'(8'h61 + k), 0);
            step();
        end
        drive(0, 0, 1, 8'h77, 1);
        step();
        chk("ce_hold_level", 32'(bus0.level), 3);
        chk("ce_hold_fwft_head", 32'(bus1.read_data), 32'h61);
        drive(1, 0, 1, 8'h78, 1);
        step();
        chk("rst_mid_level", 32'(bus0.level), 0);
        chk("rst_mid_empty", 32'(bus1.empty), 1);
        chk("rst_mid_rdata_reg", 32'(bus0.read_data), 0);
        chk("rst_mid_rdata_fwft", 32'(bus1.read_data), 0);

        // Randomised traffic with write-heavy and read-heavy phases.
        drive(0, 1, 0, 8'h00, 0);
        for (int c = 0; c < 3000; c++) begin
            wp = ((c / 200) % 2 == 0) ? 70 : 30;
            reset      = ($urandom_range(0, 199) == 0);
            clk_enable = ($urandom_range(0, 9) != 0);
            write      = ($urandom_range(0, 99) < wp);
            read       = ($urandom_range(0, 99) < 50);
            write_data = 8'($urandom);
            err_clear  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) af_thresh = LVL_W'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ae_thresh = LVL_W'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
